spi_cmd_registers: RTL

Avalon-MM write-side register block for the SpeedSPI engine. It is the command/issue counterpart of the status readback registers. Software writes a block address, a block count and an opcode. The block then presents the command to the SPI engine through a valid/ready handshake, and stays busy until the engine reports success, error or a timeout. It sits between the Avalon slave port and the SPI transfer FSM, at the same OFFSET base as the status registers.

---
 rtl/spi_cmd_registers.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spi_cmd_registers.sv
// Write-side command registers for the SpeedSPI engine: latches address, count and opcode
// from Avalon writes, issues the command over valid/ready and stays busy until completion.
module spi_cmd_registers #(
  parameter int unsigned OFFSET  = 1,
  parameter int unsigned TO_W    = 24,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avs_s0_write,
  input  logic [15:0] avs_s0_address,
  input  logic [31:0] avs_s0_writedata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [31:0] cmd_addr,
  output logic [15:0] cmd_count,
  input  logic        success,
  input  logic [1:0]  error,
  output logic        busy,
  output logic        reject,
  output logic        timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam logic [15:0]     REG_ADDR   = 16'(OFFSET + 2);
  localparam logic [15:0]     REG_COUNT  = 16'(OFFSET + 3);
  localparam logic [15:0]     REG_CTRL   = 16'(OFFSET + 4);
  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_op_q, cmd_op_d;
  logic [31:0]       cmd_addr_q, cmd_addr_d;
  logic [15:0]       cmd_count_q, cmd_count_d;
  logic              busy_q, busy_d;
  logic              reject_q, reject_d;
  logic              timeout_q, timeout_d;
  logic              idle;
  logic              op_valid;

  // Non-fatal engine errors are recorded by the status block, not here.
  wire error_nonfatal_unused = error[0];

  assign idle     = (state_q == ST_IDLE);
  assign op_valid = (avs_s0_writedata[1:0] == 2'b01) || (avs_s0_writedata[1:0] == 2'b10);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_count_d = cmd_count_q;
    reject_d    = reject_q;
    timeout_d   = timeout_q;

    if (avs_s0_write) begin
      if (avs_s0_address == REG_ADDR) begin
        if (idle) cmd_addr_d = avs_s0_writedata;
        else      reject_d   = 1'b1;
      end else if (avs_s0_address == REG_COUNT) begin
        if (idle) cmd_count_d = avs_s0_writedata[15:0];
        else      reject_d    = 1'b1;
      end else if (avs_s0_address == REG_CTRL) begin
        if (avs_s0_writedata[31]) reject_d = 1'b0;
        if (!idle) begin
          // While busy only a reject-clear is honoured; anything else is refused.
          if (!avs_s0_writedata[31]) reject_d = 1'b1;
        end else if (op_valid) begin
          if (cmd_count_q == 16'd0) begin
            reject_d = 1'b1;
          end else begin
            cmd_op_d    = avs_s0_writedata[1:0];
            state_d     = ST_ISSUE;
            cmd_valid_d = 1'b1;
            timeout_d   = 1'b0;
          end
        end else if (!(avs_s0_writedata[31] && avs_s0_writedata[1:0] == 2'b00)) begin
          // A bare clear (opcode 00 with bit 31) is not treated as a bad opcode.
          reject_d = 1'b1;
        end
      end
    end

    case (state_q)
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ST_WAIT;
          cmd_valid_d = 1'b0;
          timer_d     = '0;
        end
      end
      ST_WAIT: begin
        if (success || error[1]) begin
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 2'b00;
      cmd_addr_q  <= 32'd0;
      cmd_count_q <= 16'd0;
      busy_q      <= 1'b0;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_count_q <= cmd_count_d;
      busy_q      <= busy_d;
      reject_q    <= reject_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_count = cmd_count_q;
  assign busy      = busy_q;
  assign reject    = reject_q;
  assign timeout   = timeout_q;

endmodule
